// File: rtl/coef_bank_reader.sv
// coef_bank_reader: walks a base/length window of the coefficient bank (wrapping at BANK_DEPTH)
// and streams the entries on valid/ready. Optional macro COEF_READ_WRAP_EN: re-run the window while loop=1.
module coef_bank_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BANK_DEPTH = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  base_sel,
    input  logic [SEL_WIDTH:0]    count,
    input  logic                  loop,
    output logic [SEL_WIDTH-1:0]  rd_sel,
    input  logic [DATA_WIDTH-1:0] bank_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [SEL_WIDTH:0]   DEPTH_L = (SEL_WIDTH+1)'(BANK_DEPTH);
    localparam logic [SEL_WIDTH:0]   ONE_L   = (SEL_WIDTH+1)'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_MAX = SEL_WIDTH'(BANK_DEPTH - 1);

    state_t                  state_q;
    logic [SEL_WIDTH-1:0]    rd_sel_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    done_q;
    logic [SEL_WIDTH:0]      len_q;
    logic [SEL_WIDTH:0]      issued_q;

    logic                    handshake_d;
    logic                    wrap_restart_d;
    logic                    finish_d;
    logic [SEL_WIDTH:0]      issued_eff_d;
    logic                    load_d;
    logic                    last_load_d;
    logic [SEL_WIDTH-1:0]    rd_sel_inc_d;
    logic [SEL_WIDTH:0]      len_d;

    assign handshake_d = out_valid_q && out_ready;

`ifdef COEF_READ_WRAP_EN
    logic [SEL_WIDTH-1:0] base_q;
    assign wrap_restart_d = handshake_d && out_last_q && loop;
`else
    logic loop_unused;
    assign loop_unused    = loop;
    assign wrap_restart_d = 1'b0;
`endif

    // A wrap restart counts as issue index 0 so the next pass loads on the same edge (no bubble).
    assign finish_d     = handshake_d && out_last_q && !wrap_restart_d;
    assign issued_eff_d = wrap_restart_d ? '0 : issued_q;
    assign load_d       = (issued_eff_d < len_q) && (!out_valid_q || out_ready);
    assign last_load_d  = (issued_eff_d + ONE_L) == len_q;
    assign rd_sel_inc_d = (rd_sel_q == SEL_MAX) ? '0 : rd_sel_q + 1'b1;
    assign len_d        = (count > DEPTH_L) ? DEPTH_L : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_sel_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            len_q       <= '0;
            issued_q    <= '0;
`ifdef COEF_READ_WRAP_EN
            base_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q    <= len_d;
                        issued_q <= '0;
                        rd_sel_q <= base_sel;
`ifdef COEF_READ_WRAP_EN
                        base_q   <= base_sel;
`endif
                        state_q  <= (len_d == '0) ? DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (finish_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state_q     <= DONE;
                    end else if (load_d) begin
                        out_data_q  <= bank_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= last_load_d;
                        issued_q    <= issued_eff_d + ONE_L;
`ifdef COEF_READ_WRAP_EN
                        // Park on the window base after the final fetch so a looped pass can start at once.
                        rd_sel_q    <= last_load_d ? base_q : rd_sel_inc_d;
`else
                        rd_sel_q    <= rd_sel_inc_d;
`endif
                    end else if (handshake_d) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_sel    = rd_sel_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
